// File: rtl/alu_definitions.sv
// Shared execute-stage definitions: ALU control codes, RV32M multiply/divide
// opcodes, the multiply/divide sequencer states and a small sign helper.
package alu_definitions;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        MD_MUL,
        MD_MULH,
        MD_MULHSU,
        MD_MULHU,
        MD_DIV,
        MD_DIVU,
        MD_REM,
        MD_REMU
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } muldiv_state_t;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Absolute value of a 32-bit operand when it is treated as signed.
    function automatic logic [31:0] magnitude(input logic [31:0] value,
                                              input logic        signed_op);
        return (signed_op && value[31]) ? (32'd0 - value) : value;
    endfunction

endpackage

// File: rtl/divider_core.sv
// Unsigned restoring divider: one quotient bit per clock, 32 iterations,
// with a single-cycle done pulse after the last iteration.
module divider_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] div_q;
    logic [4:0]  count;
    logic        running;
    logic [32:0] trial;
    logic        fits;
    logic [31:0] diff;

    // Shift the next dividend bit into the partial remainder and test the subtraction.
    always_comb begin
        trial = {rem, quo[31]};
        fits  = (trial >= {1'b0, div_q});
        diff  = trial[31:0] - div_q;
    end

    // Iteration register: a new start always reloads, even over a run that was abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo     <= '0;
            rem     <= '0;
            div_q   <= '0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo     <= dividend;
                rem     <= '0;
                div_q   <= divisor;
                count   <= '0;
                running <= 1'b1;
            end else if (running) begin
                if (fits) begin
                    rem <= diff;
                    quo <= {quo[30:0], 1'b1};
                end else begin
                    rem <= trial[31:0];
                    quo <= {quo[30:0], 1'b0};
                end
                count <= count + 5'd1;
                if (count == 5'd31) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: single-cycle 33x33 multiply, iterative divide
// through divider_core, fast path for divide-by-zero and signed overflow.
module muldiv_unit
    import alu_definitions::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  muldiv_op_t  op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    muldiv_state_t state, state_next;
    muldiv_op_t    op_q;
    logic [31:0]   op1_q, op2_q;
    logic [31:0]   fin_value, fin_next;
    logic          fin_load, fast_load, fast_q;
    logic          accept, finishing;
    logic          req_is_div, req_is_rem, req_signed, req_div_zero, req_overflow;
    logic          core_start, core_done;
    logic [31:0]   core_quotient, core_remainder;
    logic [63:0]   mul_a, mul_b, product;
    logic          neg_quotient, neg_remainder;
    logic [31:0]   div_fixed;

    assign accept    = (state == IDLE) && start && !flush;
    assign finishing = (state == FIN) && !fast_q && !flush;
    assign busy      = (state != IDLE);

    // Classify the incoming request so special cases can bypass the divider.
    always_comb begin
        req_is_div   = op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
        req_is_rem   = op inside {MD_REM, MD_REMU};
        req_signed   = op inside {MD_DIV, MD_REM};
        req_div_zero = (op2 == 32'd0);
        req_overflow = req_signed && (op1 == INT_MIN) && (op2 == 32'hFFFF_FFFF);
    end

    // Sign/zero-extend the latched operands; the low 64 bits of a 64x64 product equal the 33x33 signed product.
    always_comb begin
        mul_a   = {{32{(op_q != MD_MULHU) & op1_q[31]}}, op1_q};
        mul_b   = {{32{((op_q == MD_MUL) || (op_q == MD_MULH)) & op2_q[31]}}, op2_q};
        product = mul_a * mul_b;
    end

    // Restore signs on the divider's magnitude results.
    always_comb begin
        neg_quotient  = (op_q == MD_DIV) && (op1_q[31] ^ op2_q[31]);
        neg_remainder = (op_q == MD_REM) && op1_q[31];
        if (op_q inside {MD_REM, MD_REMU})
            div_fixed = neg_remainder ? (32'd0 - core_remainder) : core_remainder;
        else
            div_fixed = neg_quotient ? (32'd0 - core_quotient) : core_quotient;
    end

    // Next-state logic; fast-path results wait one extra cycle in FIN so short operations share one latency.
    always_comb begin
        state_next = state;
        core_start = 1'b0;
        fin_load   = 1'b0;
        fast_load  = 1'b0;
        fin_next   = '0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!req_is_div) begin
                            state_next = MUL;
                        end else if (req_div_zero) begin
                            state_next = FIN;
                            fin_load   = 1'b1;
                            fast_load  = 1'b1;
                            fin_next   = req_is_rem ? op1 : 32'hFFFF_FFFF;
                        end else if (req_overflow) begin
                            state_next = FIN;
                            fin_load   = 1'b1;
                            fast_load  = 1'b1;
                            fin_next   = req_is_rem ? 32'd0 : INT_MIN;
                        end else begin
                            state_next = DIV;
                            core_start = 1'b1;
                        end
                    end
                end
                MUL: begin
                    state_next = FIN;
                    fin_load   = 1'b1;
                    fin_next   = (op_q == MD_MUL) ? product[31:0] : product[63:32];
                end
                DIV: begin
                    if (core_done) begin
                        state_next = FIN;
                        fin_load   = 1'b1;
                        fin_next   = div_fixed;
                    end
                end
                FIN: begin
                    state_next = fast_q ? FIN : IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operands are captured only on an accepted start, so a start while busy cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= MD_MUL;
            op1_q <= '0;
            op2_q <= '0;
        end else if (accept) begin
            op_q  <= op;
            op1_q <= op1;
            op2_q <= op2;
        end
    end

    // Pending result and fast-path hold flag, staged in FIN before being published.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_value <= '0;
            fast_q    <= 1'b0;
        end else begin
            if (fin_load) fin_value <= fin_next;
            if (flush)          fast_q <= 1'b0;
            else if (fast_load) fast_q <= 1'b1;
            else if (state == FIN) fast_q <= 1'b0;
        end
    end

    // Publish the result with a one-cycle done pulse; a flush in FIN leaves the old result visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= finishing;
            if (finishing) result <= fin_value;
        end
    end

    divider_core u_divider_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .dividend  (magnitude(op1, req_signed)),
        .divisor   (magnitude(op2, req_signed)),
        .quotient  (core_quotient),
        .remainder (core_remainder),
        .done      (core_done)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, flush/reset aborts
// and randomized operations checked against an arithmetic reference model.
module tb_muldiv_unit;
    import alu_definitions::*;

    typedef struct {
        logic [31:0] value;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    muldiv_op_t  op = MD_MUL;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    logic [31:0] last_exp = '0;
    exp_t        sb[$];
    exp_t        mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .op1    (op1),
        .op2    (op2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Reference result straight from RV32M arithmetic rules.
    function automatic logic [31:0] refModel(muldiv_op_t o, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            MD_MUL:    begin p = sa * sb; return p[31:0];  end
            MD_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_MULHSU: begin p = sa * ub; return p[63:32]; end
            MD_MULHU:  begin p = ua * ub; return p[63:32]; end
            MD_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return ia / ib;
            end
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM:    begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                return ia % ib;
            end
            MD_REMU:   return (b == 0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    // Edges from the accepting edge to the edge after which done is seen.
    function automatic int refLatency(muldiv_op_t o, logic [31:0] a, logic [31:0] b);
        logic is_div;
        logic is_signed;
        is_div    = o inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
        is_signed = o inside {MD_DIV, MD_REM};
        if (!is_div || b == 0 || (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 2;
        return 34;
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_idle actual=busy required=idle within 200 cycles");
    endtask

    task automatic issueOp(muldiv_op_t o, logic [31:0] a, logic [31:0] b,
                           logic [31:0] exp_value, int lat);
        exp_t e;
        waitIdle();
        op    = o;
        op1   = a;
        op2   = b;
        start = 1'b1;
        e.value = exp_value;
        e.due   = cycle + 1 + lat;
        sb.push_back(e);
        last_exp = exp_value;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic applyStimulus(muldiv_op_t o, logic [31:0] a, logic [31:0] b);
        issueOp(o, a, b, refModel(o, a, b), refLatency(o, a, b));
    endtask

    // Launch an operation whose result must never appear (it will be aborted).
    task automatic launchUnchecked(muldiv_op_t o, logic [31:0] a, logic [31:0] b);
        waitIdle();
        op    = o;
        op1   = a;
        op2   = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Monitor: every done pulse pops one expectation and checks value and timing.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=done with result %h required=no done", result);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("result", result, mon_e.value);
                checkOutput("done_cycle", 32'(cycle), 32'(mon_e.due));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b0;

        issueOp(MD_MUL, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 2);
        @(negedge clk);
        checkOutput("mul_busy_1", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("mul_busy_2", 32'(busy), 32'd1);

        issueOp(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        issueOp(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        issueOp(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

        issueOp(MD_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34);
        issueOp(MD_REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34);
        issueOp(MD_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 2);
        issueOp(MD_REMU, 32'h0000_1234, 32'd0, 32'h0000_1234, 2);
        issueOp(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        issueOp(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

        // A start while a divide is running must not touch the latched operands.
        issueOp(MD_DIVU, 32'd1000, 32'd10, 32'd100, 34);
        @(negedge clk);
        op    = MD_MUL;
        op1   = 32'd5;
        op2   = 32'd5;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;

        // Flush ten cycles into a divide: back to idle, no done, result held.
        waitIdle();
        launchUnchecked(MD_DIV, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_result", result, last_exp);
        repeat (40) @(negedge clk);
        checkOutput("flush_result_hold", result, last_exp);

        // Flush and start together: the start is not accepted.
        start = 1'b1;
        flush = 1'b1;
        op    = MD_MUL;
        op1   = 32'd3;
        op2   = 32'd3;
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clk);
        checkOutput("flush_start_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        // Reset five cycles into a divide clears everything at once.
        launchUnchecked(MD_DIV, 32'd5000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("rst_no_done_result", result, 32'd0);

        issueOp(MD_DIVU, 32'd100, 32'd7, 32'd14, 34);
        issueOp(MD_REMU, 32'd100, 32'd7, 32'd2, 34);

        // Randomized operations with biased corner operands.
        for (int i = 0; i < 40; i++) begin
            muldiv_op_t  o;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            o   = muldiv_op_t'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
            if (sel == 3) b = 32'(-$urandom_range(1, 20));
            applyStimulus(o, a, b);
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain actual=%0d pending required=0 pending", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; all latencies are fixed by this document.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request strobe, accepted only in IDLE.
REQ-005 op  input  muldiv_op_t  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (RV32M).
REQ-006 op1  input  32  rs1 operand, same source as the ALU's first operand.
REQ-007 op2  input  32  rs2 operand, same source as the ALU's second operand.
REQ-008 flush  input  1  pipeline kill; aborts any operation in progress.
REQ-009 busy  output  1  high while an operation is in flight; hazard unit stalls execute on it.
REQ-010 done  output  1  one-cycle pulse marking result valid.
REQ-011 result  output  32  result, muxed with the ALU result at execute output.

Function
REQ-012 States SHALL be IDLE, MUL, DIV, FIN; op, op1 and op2 SHALL be latched on the accepted start edge.
REQ-013 start in IDLE with flush low SHALL be accepted; start in any other state SHALL be ignored, with no effect on latched operands.
REQ-014 busy SHALL be high in MUL, DIV and FIN, and low in IDLE.
REQ-015 Multiply path (start accepted at edge T):
- MUL SHALL compute a 33x33 signed product of sign- or zero-extended operands in one cycle.
- Extension: MULHSU = op1 signed, op2 unsigned; MULHU = both unsigned; MUL/MULH = both signed.
- Next state FIN; done SHALL pulse in the cycle after edge T+2.
REQ-016 Multiply result: MUL = product[31:0]; MULH, MULHSU and MULHU = product[63:32].
REQ-017 Divide path: DIV/REM SHALL use restoring division on operand magnitudes.
- 32 iterations, one quotient bit per cycle.
- Then FIN; done SHALL pulse in the cycle after edge T+34.
REQ-018 Signed fix-up: quotient negated when operand signs differ; remainder takes op1's sign.
REQ-019 Divide by zero (op2 = 0) SHALL take the fast path (IDLE->FIN, done at T+2):
- DIV/DIVU = 0xFFFFFFFF.
- REM/REMU = op1.
REQ-020 Signed overflow (op1 = 0x80000000, op2 = 0xFFFFFFFF) SHALL take the fast path:
- DIV = 0x80000000.
- REM = 0.
REQ-021 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 result SHALL hold its value from FIN until the next accepted operation reaches FIN.
REQ-023 flush high SHALL force IDLE on the next edge from any state, with done suppressed and result unchanged.
REQ-024 flush and start asserted in the same cycle: flush SHALL win and start SHALL NOT be accepted.

Reset
REQ-025 rst high SHALL immediately force state IDLE, busy = 0, done = 0, result = 0, iteration counter = 0, latched operands = 0.
REQ-026 rst asserted mid-operation SHALL discard the operation; no done SHALL follow reset release.

Structure
REQ-027 muldiv_op_t (3-bit enum) SHALL live in the shared alu_definitions package, next to alu_ctrl_t.
REQ-028 The iterative divider SHALL be one sub-module, divider_core, with:
- inputs: start, unsigned dividend, unsigned divisor.
- outputs: quotient, remainder, done.
- it SHALL have the same clk/rst ports.
REQ-029 Sign handling, special-case detection and the state machine SHALL stay in muldiv_unit.

Verification
REQ-030 MUL, op1 = 0xFFFFFFFF (-1), op2 = 7 -> result 0xFFFFFFF9; done two cycles after start; busy high in between.
REQ-031 MULHU, op1 = op2 = 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU with the same operands -> 0xFFFFFFFF.
REQ-032 DIV, op1 = -20 (0xFFFFFFEC), op2 = 3 -> quotient 0xFFFFFFFA, done at T+34; REM with the same operands -> 0xFFFFFFFE.
REQ-033 DIVU, op2 = 0, op1 = 0x1234 -> 0xFFFFFFFF at T+2; REMU -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-034 DIV started, flush at cycle 10 -> IDLE next edge, no done, result keeps prior value; start during busy ignored.
REQ-035 rst pulsed at cycle 5 of DIV -> all outputs 0 immediately; a subsequent DIVU 100/7 returns 14 with REMU 2.
